div_issue_ctrl: RTL and testbench

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/div_issue_ctrl_pkg.sv | 27 ++
 rtl/div_issue_ctrl_if.sv | 36 +++
 rtl/div_issue_ctrl_track_pipe.sv | 46 ++++
 rtl/div_issue_ctrl.sv | 108 ++++++++++
 tb/tb_div_issue_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared constants and types for the divide issue controller.
// Revision : 1.0
// ============================================================================
package div_pkg;

    localparam int LAT  = 16;
    localparam int TAGW = 4;

    // {dividend sign, divisor sign}
    typedef logic [1:0] sign_code_t;

    typedef struct packed {
        logic       valid;
        logic       is_signed;
        sign_code_t sgn;
        logic       dz;
    } track_meta_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl_if
// Brief    : EX request / WB result handshake bundle for div_issue_ctrl.
// Revision : 1.0
// ============================================================================
interface div_issue_ctrl_if #(
    parameter int TAGW = div_pkg::TAGW
) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_signed;
    logic [31:0]     req_dividend;
    logic [31:0]     req_divisor;
    logic [TAGW-1:0] req_tag;

    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_quotient;
    logic [31:0]     res_remainder;
    logic [TAGW-1:0] res_tag;
    logic            res_dz;

    modport master (
        output req_valid, req_signed, req_dividend, req_divisor, req_tag, res_ready,
        input  req_ready, res_valid, res_quotient, res_remainder, res_tag, res_dz
    );

    modport slave (
        input  req_valid, req_signed, req_dividend, req_divisor, req_tag, res_ready,
        output req_ready, res_valid, res_quotient, res_remainder, res_tag, res_dz
    );

endinterface
`default_nettype wire

// File: rtl/div_issue_ctrl_track_pipe.sv
`default_nettype none
// ============================================================================
// Module   : div_track_pipe
// Brief    : LAT-stage shift register of per-op metadata, lock-stepped with the divider.
// Revision : 1.0
// ============================================================================
module div_track_pipe #(
    parameter int LAT  = div_pkg::LAT,
    parameter int TAGW = div_pkg::TAGW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 clear,
    input  div_pkg::track_meta_t push_meta,
    input  logic [TAGW-1:0]      push_tag,
    output div_pkg::track_meta_t head_meta,
    output logic [TAGW-1:0]      head_tag
);
    import div_pkg::*;

    track_meta_t     r_meta [LAT];
    logic [TAGW-1:0] r_tag  [LAT];

    // Clear takes priority over hold so a flush during a stall drops the held op.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < LAT; i++) begin
                r_meta[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else if (!hold) begin
            r_meta[0] <= push_meta;
            r_tag[0]  <= push_tag;
            for (int i = 1; i < LAT; i++) begin
                r_meta[i] <= r_meta[i-1];
                r_tag[i]  <= r_tag[i-1];
            end
        end
    end

    assign head_meta = r_meta[LAT-1];
    assign head_tag  = r_tag[LAT-1];

endmodule
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Brief    : Issues signed/unsigned divides to a fixed-latency unsigned divider
//            and applies sign fix-up to its results.
// Revision : 1.0
// ============================================================================
module div_issue_ctrl #(
    parameter int LAT  = div_pkg::LAT,
    parameter int TAGW = div_pkg::TAGW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    div_issue_ctrl_if.slave            bus,
    output logic [31:0]                div_dividend,
    output logic [31:0]                div_divisor,
    output logic                       div_stall,
    output logic                       div_flush,
    input  logic [31:0]                div_quotient,
    input  logic [31:0]                div_remainder,
    output logic [$clog2(LAT+1)-1:0]   inflight,
    output logic                       idle
);
    import div_pkg::*;

    localparam int c_CNT_W = $clog2(LAT+1);

    logic               w_res_valid;
    logic               w_stall;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_res_hs;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_neg_q;
    logic               w_neg_r;
    track_meta_t        w_push_meta;
    track_meta_t        w_head_meta;
    logic [TAGW-1:0]    w_head_tag;
    logic [31:0]        w_quot_fix;
    logic [31:0]        w_rem_fix;
    logic [c_CNT_W-1:0] r_inflight;

    // Outputs are forced quiet while reset is held, before any edge clears state.
    assign w_res_valid = w_head_meta.valid && !reset;
    assign w_stall     = w_res_valid && !bus.res_ready;
    assign w_req_ready = !reset && !w_stall && !flush;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_res_hs    = w_res_valid && bus.res_ready;

    assign w_neg_a = bus.req_signed && bus.req_dividend[31];
    assign w_neg_b = bus.req_signed && bus.req_divisor[31];

    assign div_dividend = mag32(bus.req_dividend, w_neg_a);
    assign div_divisor  = mag32(bus.req_divisor,  w_neg_b);
    assign div_stall    = w_stall;
    assign div_flush    = flush || reset;

    always_comb begin
        w_push_meta           = '0;
        w_push_meta.valid     = w_accept;
        w_push_meta.is_signed = bus.req_signed;
        w_push_meta.sgn       = {w_neg_a, w_neg_b};
        w_push_meta.dz        = (bus.req_divisor == 32'd0);
    end

    div_track_pipe #(
        .LAT  (LAT),
        .TAGW (TAGW)
    ) u_track (
        .clk       (clk),
        .reset     (reset),
        .hold      (w_stall),
        .clear     (flush),
        .push_meta (w_push_meta),
        .push_tag  (bus.req_tag),
        .head_meta (w_head_meta),
        .head_tag  (w_head_tag)
    );

    assign w_neg_q    = w_head_meta.is_signed && (w_head_meta.sgn[1] ^ w_head_meta.sgn[0]);
    assign w_neg_r    = w_head_meta.is_signed && w_head_meta.sgn[1];
    assign w_quot_fix = mag32(div_quotient,  w_neg_q);
    assign w_rem_fix  = mag32(div_remainder, w_neg_r);

    assign bus.req_ready     = w_req_ready;
    assign bus.res_valid     = w_res_valid;
    assign bus.res_quotient  = reset ? 32'd0 : w_quot_fix;
    assign bus.res_remainder = reset ? 32'd0 : w_rem_fix;
    assign bus.res_tag       = reset ? '0    : w_head_tag;
    assign bus.res_dz        = !reset && w_head_meta.dz;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_inflight <= '0;
        end else if (w_accept && !w_res_hs) begin
            r_inflight <= r_inflight + c_CNT_W'(1);
        end else if (!w_accept && w_res_hs) begin
            r_inflight <= r_inflight - c_CNT_W'(1);
        end
    end

    assign inflight = r_inflight;
    assign idle     = (r_inflight == '0);

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_issue_ctrl
// Brief    : Directed self-checking bench for div_issue_ctrl with a 16-cycle divider model.
// Revision : 1.0
// ============================================================================
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_stall;
    logic        div_flush;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic [4:0]  inflight;
    logic        idle;

    int n_vec = 0;
    int n_err = 0;

    div_issue_ctrl_if #(.TAGW(4)) bus ();

    div_issue_ctrl #(.LAT(16), .TAGW(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .bus           (bus),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_stall     (div_stall),
        .div_flush     (div_flush),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .inflight      (inflight),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    // Unsigned divider: 16 stages, freezes on stall, q=all-ones / r=dividend on zero divisor.
    logic [31:0] m_q [16];
    logic [31:0] m_r [16];
    always @(posedge clk) begin
        if (!div_stall) begin
            m_q[0] <= (div_divisor == 32'd0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
            m_r[0] <= (div_divisor == 32'd0) ? div_dividend  : div_dividend % div_divisor;
            for (int i = 1; i < 16; i++) begin
                m_q[i] <= m_q[i-1];
                m_r[i] <= m_r[i-1];
            end
        end
    end
    assign div_quotient  = m_q[15];
    assign div_remainder = m_r[15];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_valid    = 1'b0;
        bus.req_signed   = 1'b0;
        bus.req_dividend = 32'd0;
        bus.req_divisor  = 32'd0;
        bus.req_tag      = 4'd0;
    endtask

    task automatic run_single(input logic s, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] tg, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int early;
        next_cycle();
        bus.req_valid    = 1'b1;
        bus.req_signed   = s;
        bus.req_dividend = a;
        bus.req_divisor  = b;
        bus.req_tag      = tg;
        #1;
        check("single_ready", bus.req_ready, 1);
        check("single_mag", {div_dividend, div_divisor}, {ea, eb});
        next_cycle();
        drive_idle();
        early = 0;
        for (int k = 1; k < 16; k++) begin
            #1;
            if (bus.res_valid) early++;
            next_cycle();
        end
        #1;
        check("single_early", early, 0);
        check("single_valid", bus.res_valid, 1);
        check("single_qr", {bus.res_quotient, bus.res_remainder}, {eq, er});
        check("single_tagdz", {bus.res_tag, bus.res_dz}, {tg, edz});
        check("single_inflight", inflight, 1);
        next_cycle();
        #1;
        check("single_drain", {bus.res_valid, idle}, 2'b01);
    endtask

    logic [31:0] exp_q [20];
    logic [31:0] exp_r [20];

    initial begin
        int issued, recv, lowcnt, peak, c, seen;

        reset         = 1'b1;
        flush         = 1'b0;
        bus.res_ready = 1'b1;
        drive_idle();

        // Reset, before and after a clock edge
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_dflush", div_flush, 1);
        check("rst_rvalid", bus.res_valid, 0);
        next_cycle();
        next_cycle();
        #1;
        check("rst_count", {inflight, idle}, {5'd0, 1'b1});
        check("rst_qr", {bus.res_quotient, bus.res_remainder}, 64'd0);
        check("rst_tagdz", {bus.res_tag, bus.res_dz}, 5'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        check("post_rst", {bus.req_ready, idle, div_flush}, 3'b110);

        // Single ops covering sign fix-up, overflow and divide-by-zero
        run_single(1'b1, 32'hFFFF_FFF9, 32'd2,         4'h3, 32'd7,         32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_single(1'b0, 32'hFFFF_FFF9, 32'd2,         4'h5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1,         1'b0);
        run_single(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hA, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0,         1'b0);
        run_single(1'b1, 32'd7,         32'd0,         4'h1, 32'd7,         32'd0, 32'hFFFF_FFFF, 32'd7,         1'b1);
        run_single(1'b1, 32'hFFFF_FFF9, 32'd0,         4'h2, 32'd7,         32'd0, 32'd1,         32'hFFFF_FFF9, 1'b1);
        run_single(1'b1, 32'd7,         32'hFFFF_FFFE, 4'hF, 32'd7,         32'd2, 32'hFFFF_FFFD, 32'd1,         1'b0);
        run_single(1'b0, 32'd100,       32'd0,         4'h6, 32'd100,       32'd0, 32'hFFFF_FFFF, 32'd100,       1'b1);

        // 20 back-to-back ops with a 3-cycle WB stall on the first result
        for (int i = 0; i < 20; i++) begin
            exp_q[i] = (32'd1000 + 32'(i)) / 32'd7;
            exp_r[i] = (32'd1000 + 32'(i)) % 32'd7;
        end
        issued = 0; recv = 0; lowcnt = 0; peak = 0; c = 0;
        while (recv < 20 && c < 200) begin
            next_cycle();
            if (issued < 20) begin
                bus.req_valid    = 1'b1;
                bus.req_signed   = 1'b0;
                bus.req_dividend = 32'd1000 + 32'(issued);
                bus.req_divisor  = 32'd7;
                bus.req_tag      = 4'(issued);
            end else begin
                drive_idle();
            end
            bus.res_ready = !(c >= 16 && c <= 18);
            #1;
            if (c == 16) check("b2b_latency", bus.res_valid, 1);
            if (bus.req_valid && !bus.req_ready) lowcnt++;
            if (int'(inflight) > peak) peak = int'(inflight);
            if (bus.res_valid && !bus.res_ready)
                check("b2b_hold", {bus.res_tag, bus.res_quotient, bus.res_remainder},
                      {4'd0, exp_q[0], exp_r[0]});
            if (bus.res_valid && bus.res_ready) begin
                check("b2b_result", {bus.res_tag, bus.res_quotient, bus.res_remainder},
                      {4'(recv), exp_q[recv], exp_r[recv]});
                recv++;
            end
            if (bus.req_valid && bus.req_ready) issued++;
            c++;
        end
        check("b2b_count", recv, 20);
        check("b2b_ready_low", lowcnt, 3);
        check("b2b_peak", peak, 16);
        bus.res_ready = 1'b1;
        drive_idle();
        next_cycle();
        #1;
        check("b2b_idle", idle, 1);

        // Flush with five ops in flight
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            bus.req_valid    = 1'b1;
            bus.req_signed   = 1'b1;
            bus.req_dividend = 32'd30 + 32'(i);
            bus.req_divisor  = 32'd3;
            bus.req_tag      = 4'(i);
        end
        next_cycle();
        drive_idle();
        next_cycle();
        #1;
        check("fl_pre_inflight", inflight, 5);
        next_cycle();
        flush            = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_dividend = 32'd9;
        bus.req_divisor  = 32'd3;
        #1;
        check("fl_ready", bus.req_ready, 0);
        check("fl_dflush", div_flush, 1);
        next_cycle();
        flush = 1'b0;
        drive_idle();
        #1;
        check("fl_post", {inflight, idle, bus.res_valid}, {5'd0, 1'b1, 1'b0});
        seen = 0;
        repeat (30) begin
            next_cycle();
            #1;
            if (bus.res_valid) seen++;
        end
        check("fl_no_result", seen, 0);
        run_single(1'b0, 32'd100, 32'd7, 4'h9, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Reset with eight ops in flight
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            bus.req_valid    = 1'b1;
            bus.req_signed   = 1'b0;
            bus.req_dividend = 32'd50 + 32'(i);
            bus.req_divisor  = 32'd5;
            bus.req_tag      = 4'(i + 1);
        end
        next_cycle();
        drive_idle();
        reset = 1'b1;
        #1;
        check("mr_inflight_pre", inflight, 8);
        check("mr_gate", {bus.req_ready, bus.res_valid, div_flush}, 3'b001);
        check("mr_data", {bus.res_quotient, bus.res_remainder, bus.res_tag, bus.res_dz}, 69'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check("mr_release", {inflight, idle, bus.req_ready}, {5'd0, 1'b1, 1'b1});
        seen = 0;
        repeat (40) begin
            next_cycle();
            #1;
            if (bus.res_valid) seen++;
        end
        check("mr_no_result", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
